if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 136 +++++++++++++
 tb/tb_if_id_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with valid/ready handshake, flush and saturating stall counter.
// Define IF_ID_SKID_BUF_EN to add a one-entry skid buffer that registers in_ready.
module if_id_stage #(
  parameter int unsigned        PC_W     = 32,
  parameter int unsigned        INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = '0,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, retire;

  assign retire = out_valid_q & out_ready;
  assign accept = in_valid & in_ready;

`ifdef IF_ID_SKID_BUF_EN
  logic              skid_full_q, skid_full_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;

  // Readiness depends only on skid occupancy, never on out_ready.
  assign in_ready = ~skid_full_q & ~flush & rst_n;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    skid_full_d = skid_full_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_inst_d  = NOP_INST;
      skid_full_d = 1'b0;
    end else if (retire) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = skid_pc_q;
        out_inst_d  = skid_inst_q;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_pc_d    = in_pc;
        out_inst_d  = in_inst;
      end else begin
        out_valid_d = 1'b0;
        out_inst_d  = NOP_INST;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_pc_d    = in_pc;
        out_inst_d  = in_inst;
      end else begin
        skid_full_d = 1'b1;
        skid_pc_d   = in_pc;
        skid_inst_d = in_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full_q <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      skid_full_q <= skid_full_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end
`else
  assign in_ready = (~out_valid_q | out_ready) & ~flush & rst_n;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_inst_d  = NOP_INST;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_inst_d  = in_inst;
    end else if (retire) begin
      out_valid_d = 1'b0;
      out_inst_d  = NOP_INST;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= NOP_INST;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; expectations adapt to IF_ID_SKID_BUF_EN.
module tb_if_id_stage;

`ifdef IF_ID_SKID_BUF_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [15:0] stall_cnt;
  logic        in_ready_s, out_valid_s;
  logic [31:0] out_pc_s, out_inst_s;
  logic [3:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .stall_cnt(stall_cnt)
  );

  if_id_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_pc(out_pc_s), .out_inst(out_inst_s), .stall_cnt(stall_cnt_s)
  );

  typedef struct {
    logic        in_valid;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        flush;
    logic        probe;
    logic        exp_in_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [15:0] exp_stall;
  } vec_t;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                              input logic fl, input logic exp_ir, input logic exp_v,
                              input logic [31:0] exp_pc, input logic [15:0] exp_st,
                              input logic probe);
    vec_t v;
    v.in_valid = iv; v.in_pc = pc; v.out_ready = ordy; v.flush = fl; v.probe = probe;
    v.exp_in_ready = exp_ir; v.exp_valid = exp_v; v.exp_pc = exp_pc;
    v.exp_inst = exp_v ? inst_of(exp_pc) : 32'h0;
    v.exp_stall = exp_st;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; applies inputs and checks across the next edge.
  task automatic run_vec(input vec_t v, input string tag);
    in_valid = v.in_valid; in_pc = v.in_pc; in_inst = inst_of(v.in_pc);
    out_ready = v.out_ready; flush = v.flush;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(v.exp_in_ready));
    if (v.probe) begin
      out_ready = ~v.out_ready;
      #1;
      check({tag, ".in_ready_indep"}, 64'(in_ready), 64'(v.exp_in_ready));
      out_ready = v.out_ready;
    end
    @(posedge clk); #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v.exp_valid));
    check({tag, ".out_pc"}, 64'(out_pc), 64'(v.exp_pc));
    check({tag, ".out_inst"}, 64'(out_inst), 64'(v.exp_inst));
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(v.exp_stall));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".rst_pc"}, 64'(out_pc), 64'd0);
    check({tag, ".rst_inst"}, 64'(out_inst), 64'd0);
    check({tag, ".rst_stall"}, 64'(stall_cnt), 64'd0);
    check({tag, ".rst_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, ".rst_stall_sat"}, 64'(stall_cnt_s), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(1, 32'h00, 1, 0, 1,     1, 32'h00, 0, 0);
    tbl[1]  = mk(1, 32'h04, 1, 0, 1,     1, 32'h04, 0, 0);
    tbl[2]  = mk(1, 32'h08, 1, 0, 1,     1, 32'h08, 0, 0);
    tbl[3]  = mk(0, 32'h00, 1, 0, 1,     0, 32'h08, 0, 0);
    tbl[4]  = mk(1, 32'h10, 0, 0, 1,     1, 32'h10, 0, 0);
    tbl[5]  = mk(0, 32'h00, 0, 0, SKID,  1, 32'h10, 1, 0);
    tbl[6]  = mk(0, 32'h00, 0, 0, SKID,  1, 32'h10, 2, 0);
    tbl[7]  = mk(0, 32'h00, 0, 0, SKID,  1, 32'h10, 3, 0);
    tbl[8]  = mk(0, 32'h00, 1, 0, 1,     0, 32'h10, 3, 0);
    tbl[9]  = mk(1, 32'h1C, 0, 0, 1,     1, 32'h1C, 3, 0);
    tbl[10] = mk(1, 32'h20, 0, 1, 0,     0, 32'h1C, 3, 0);
    tbl[11] = mk(0, 32'h00, 1, 0, 1,     0, 32'h1C, 3, 0);

    rst_n = 1'b1;
    #1;
    do_reset("init");

    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Stall with a second beat offered: skid holds it, otherwise the source keeps offering it.
    do_reset("stall");
    run_vec(mk(1, 32'h10, 1, 0, 1, 1, 32'h10, 0, 0), "stall_c1");
    run_vec(mk(1, 32'h14, 0, 0, SKID, 1, 32'h10, 1, SKID), "stall_c2");
    run_vec(mk(!SKID, 32'h14, 0, 0, 0, 1, 32'h10, 2, SKID), "stall_c3");
    run_vec(mk(!SKID, 32'h14, 0, 0, 0, 1, 32'h10, 3, 0), "stall_c4");
    run_vec(mk(!SKID, 32'h14, 1, 0, !SKID, 1, 32'h14, 3, 0), "stall_c5");
    run_vec(mk(0, 32'h00, 1, 0, 1, 0, 32'h14, 3, 0), "stall_c6");

    // Flush while stalled, with a pending beat in skid when present.
    do_reset("flush");
    run_vec(mk(1, 32'h18, 0, 0, 1, 1, 32'h18, 0, 0), "flush_d1");
    run_vec(mk(1, 32'h1C, 0, 0, SKID, 1, 32'h18, 1, 0), "flush_d2");
    run_vec(mk(1, 32'h20, 0, 1, 0, 0, 32'h18, 1, 0), "flush_d3");
    run_vec(mk(0, 32'h00, 1, 0, 1, 0, 32'h18, 1, 0), "flush_d4");

    // Asynchronous reset mid-stall, then accept on the first edge after release.
    do_reset("mid");
    run_vec(mk(1, 32'h100, 0, 0, 1, 1, 32'h100, 0, 0), "mid_r1");
    run_vec(mk(1, 32'h104, 0, 0, SKID, 1, 32'h100, 1, 0), "mid_r2");
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_pc = 32'h200; in_inst = inst_of(32'h200); out_ready = 1'b1;
    #1;
    check("mid_first.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("mid_first.out_valid", 64'(out_valid), 64'd1);
    check("mid_first.out_pc", 64'(out_pc), 64'h200);
    run_vec(mk(0, 32'h00, 1, 0, 1, 0, 32'h200, 0, 0), "mid_drain");

    // Saturation of the 4-bit counter over 20 stall cycles.
    do_reset("sat");
    run_vec(mk(1, 32'h40, 0, 0, 1, 1, 32'h40, 0, 0), "sat_load");
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 14) check("sat_at15", 64'(stall_cnt_s), 64'd15);
    end
    check("sat_final", 64'(stall_cnt_s), 64'd15);
    check("sat_wide", 64'(stall_cnt), 64'd20);
    check("sat_hold_pc", 64'(out_pc_s), 64'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
